seq_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller. It holds a runtime-configurable pattern of 1 to PAT_W bits, selects overlapping or non-overlapping matching, and arms and disarms detection on command. It qualifies input bits with a valid strobe, counts matches, and stops after a programmed match limit. It sits between the control/register layer and the serial input stream, replacing the fixed hard-wired detectors.

---
 rtl/seq_detect_ctrl_if.sv | 36 +++
 rtl/seq_detect_ctrl.sv | 117 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Bundle of configuration, command, serial-input and status signals for seq_detect_ctrl.
// The master drives config/commands/bits; the slave is the detector itself.
interface seq_detect_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
);
   // Handshake: a config transfer happens on a rising edge where cfg_valid && cfg_ready;
   // in_valid has no back-pressure, each cycle with in_valid=1 in ARMED offers exactly one bit.
   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;
   logic [3:0]       cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_limit;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic             in;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
   logic             done;
   logic [1:0]       state_dbg;

   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
      output start, abort, in_valid, in,
      input  cfg_ready, match, match_count, busy, done, state_dbg
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
      input  start, abort, in_valid, in,
      output cfg_ready, match, match_count, busy, done, state_dbg
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: runtime pattern/length, overlap mode,
// arm/disarm commands and a saturating match counter with optional stop limit.
module seq_detect_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   seq_detect_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [3:0] LEN_MAX = 4'(PAT_W);

   state_t           r_state;
   state_t           w_state_nx;
   logic [PAT_W-1:0] r_pattern;
   logic [3:0]       r_len;
   logic             r_overlap;
   logic [CNT_W-1:0] r_limit;
   logic [PAT_W-1:0] r_hist;
   logic [3:0]       r_fill;
   logic             r_match;
   logic [CNT_W-1:0] r_count;

   logic             w_cfg_fire;
   logic             w_clear;
   logic             w_accept;
   logic [PAT_W-1:0] w_hist_nx;
   logic [PAT_W-1:0] w_mask;
   logic [3:0]       w_fill_inc;
   logic [3:0]       w_len_clamped;
   logic             w_hit;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_limit_hit;

   always_comb begin
      w_cfg_fire    = bus.cfg_valid && (r_state == S_IDLE);
      w_clear       = bus.start && !bus.abort;
      w_accept      = (r_state == S_ARMED) && bus.in_valid && !bus.start && !bus.abort;
      w_hist_nx     = {r_hist[PAT_W-2:0], bus.in};
      w_fill_inc    = (r_fill >= r_len) ? r_len : r_fill + 4'd1;
      w_len_clamped = (bus.cfg_len == 4'd0)   ? 4'd1 :
                      (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
      w_mask        = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (4'(i) < r_len);
      end
      // Match is judged on the history and fill as they will be after this bit
      w_hit         = w_accept && (w_fill_inc == r_len) &&
                      (((w_hist_nx ^ r_pattern) & w_mask) == '0);
      w_count_inc   = (r_count == '1) ? r_count : r_count + CNT_W'(1);
      w_limit_hit   = w_hit && (r_limit != '0) && (w_count_inc == r_limit);
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.abort) w_state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (bus.abort)        w_state_nx = S_IDLE;
            else if (bus.start)   w_state_nx = S_ARMED;
            else if (w_limit_hit) w_state_nx = S_DONE;
         end
         S_DONE: begin
            if (bus.abort)      w_state_nx = S_IDLE;
            else if (bus.start) w_state_nx = S_ARMED;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pattern <= '0;
         r_len     <= LEN_MAX;
         r_overlap <= 1'b0;
         r_limit   <= '0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_match   <= 1'b0;
         r_count   <= '0;
      end else begin
         if (w_cfg_fire) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= bus.cfg_overlap;
            r_limit   <= bus.cfg_limit;
         end
         r_match <= w_hit;
         if (w_clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
         end else if (w_accept) begin
            r_hist <= w_hist_nx;
            // Non-overlapping mode forces a full fresh pattern after every match
            r_fill <= (w_hit && !r_overlap) ? 4'd0 : w_fill_inc;
            if (w_hit) r_count <= w_count_inc;
         end
      end
   end

   assign bus.cfg_ready   = (r_state == S_IDLE);
   assign bus.busy        = (r_state == S_ARMED);
   assign bus.done        = (r_state == S_DONE);
   assign bus.match       = r_match;
   assign bus.match_count = r_count;
   assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: each scenario task drives vectors and checks
// outputs against hand-computed expectations one time unit after the rising edge.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int total;
  int bad;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic [7:0] lim);
    bus.cfg_valid = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len = len;
    bus.cfg_overlap = ovl;
    bus.cfg_limit = lim;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.in_valid = 1'b1;
    bus.in = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_limit = 0; bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", bus.match); end
    total++; if (bus.match_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.match_count); end
    total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s = 7'b1011011;
    logic [6:0] m = 7'b0001000;
    do_cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
    do_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nonovl_busy got=%b exp=1", bus.busy); end
    for (int i = 0; i < 7; i++) begin
      send_bit(s[6-i]);
      total++; if (bus.match !== m[6-i]) begin bad++; $display("FAIL nonovl_match bit=%0d got=%b exp=%b", i+1, bus.match, m[6-i]); end
    end
    total++; if (bus.match_count !== 8'd1) begin bad++; $display("FAIL nonovl_count got=%0d exp=1", bus.match_count); end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    logic [6:0] m = 7'b0001001;
    do_abort();
    do_cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 7; i++) begin
      send_bit(s[6-i]);
      total++; if (bus.match !== m[6-i]) begin bad++; $display("FAIL ovl_match bit=%0d got=%b exp=%b", i+1, bus.match, m[6-i]); end
    end
    total++; if (bus.match_count !== 8'd2) begin bad++; $display("FAIL ovl_count got=%0d exp=2", bus.match_count); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ovl_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_limit();
    logic [10:0] s = 11'b1011011_1011;
    do_abort();
    do_cfg(8'b0000_1011, 4'd4, 1'b1, 8'd2);
    do_start();
    for (int i = 0; i < 7; i++) send_bit(s[10-i]);
    total++; if (bus.match !== 1'b1) begin bad++; $display("FAIL limit_match got=%b exp=1", bus.match); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL limit_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL limit_busy got=%b exp=0", bus.busy); end
    for (int i = 7; i < 11; i++) begin
      send_bit(s[10-i]);
      total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL limit_after bit=%0d got=%b exp=0", i+1, bus.match); end
    end
    total++; if (bus.match_count !== 8'd2) begin bad++; $display("FAIL limit_count got=%0d exp=2", bus.match_count); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL limit_hold_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_gaps();
    do_abort();
    do_cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in = 1'b1;
      tick();
      total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL gap_idle cyc=%0d got=%b exp=0", i, bus.match); end
    end
    send_bit(1'b1);
    total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL gap_bit3 got=%b exp=0", bus.match); end
    send_bit(1'b1);
    total++; if (bus.match !== 1'b1) begin bad++; $display("FAIL gap_bit4 got=%b exp=1", bus.match); end
    total++; if (bus.match_count !== 8'd1) begin bad++; $display("FAIL gap_count got=%0d exp=1", bus.match_count); end
  endtask

  task automatic test_cfg_blocked();
    logic [5:0] s = 6'b111011;
    logic [5:0] m = 6'b000001;
    bus.cfg_valid = 1'b1;
    bus.cfg_pattern = 8'b0000_0011;
    bus.cfg_len = 4'd2;
    bus.cfg_overlap = 1'b1;
    bus.cfg_limit = 8'd0;
    #1;
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL cfgblk_ready got=%b exp=0", bus.cfg_ready); end
    tick();
    bus.cfg_valid = 1'b0;
    do_start();
    for (int i = 0; i < 6; i++) begin
      send_bit(s[5-i]);
      total++; if (bus.match !== m[5-i]) begin bad++; $display("FAIL cfgblk_match bit=%0d got=%b exp=%b", i+1, bus.match, m[5-i]); end
    end
  endtask

  task automatic test_start_abort();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL sa_pre_busy got=%b exp=1", bus.busy); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL sa_state got=%0d exp=0", bus.state_dbg); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL sa_cfg_ready got=%b exp=1", bus.cfg_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sa_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    do_cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    total++; if (bus.match !== 1'b1) begin bad++; $display("FAIL rmid_pre_match got=%b exp=1", bus.match); end
    bus.in_valid = 1'b1;
    bus.in = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL rmid_match got=%b exp=0", bus.match); end
    total++; if (bus.match_count !== 8'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.match_count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_cfg_ready got=%b exp=1", bus.cfg_ready); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0);
      total++; if (bus.match !== (i == 7)) begin bad++; $display("FAIL rmid_defcfg bit=%0d got=%b exp=%b", i+1, bus.match, (i == 7)); end
    end
  endtask

  task automatic test_len_clamp();
    logic [3:0] s = 4'b1101;
    logic [7:0] s2 = 8'b1010_0101;
    do_abort();
    do_cfg(8'b0000_0001, 4'd0, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_bit(s[3-i]);
      total++; if (bus.match !== s[3-i]) begin bad++; $display("FAIL len0_match bit=%0d got=%b exp=%b", i+1, bus.match, s[3-i]); end
    end
    total++; if (bus.match_count !== 8'd3) begin bad++; $display("FAIL len0_count got=%0d exp=3", bus.match_count); end
    do_abort();
    do_cfg(8'hA5, 4'd15, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(s2[7-i]);
      total++; if (bus.match !== (i == 7)) begin bad++; $display("FAIL lenmax_match bit=%0d got=%b exp=%b", i+1, bus.match, (i == 7)); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_limit();
    test_gaps();
    test_cfg_blocked();
    test_start_abort();
    test_reset_mid();
    test_len_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
